// File: rtl/sa_rdata_channel.sv
// ---------------------------------------------------------------------------
// sa_rdata_channel
//   Slave-side read-data return path of the interconnect. The read-address
//   channel pushes one order record per issued (possibly 4KB-split) burst;
//   R beats coming back from the slave are steered to the dispatcher of the
//   owning master, the master-ID prefix is stripped from RID, and the first
//   half of a split burst has its RLAST suppressed so the master sees a
//   single RLAST per original burst.
//
// Ports
//   ACLK_i, ARESET_i           clock, synchronous active-high reset
//   xADDR_*_i                  order record pushed by the address channel
//   xDATA_stall_o              order FIFO full
//   s_R*_i / s_RREADY_o        slave R channel
//   dsp_R*_o / dsp_RREADY_i    R channel towards the master dispatchers
//                              (payload shared, valid/ready per master)
//   prot_err_o                 sticky protocol-error flag
//
// Build option
//   SA_RDATA_OUT_REG_EN        when defined, a 2-entry skid buffer registers
//                              the dsp_R* outputs (1-cycle latency, full
//                              throughput). Undefined: zero-latency path.
// ---------------------------------------------------------------------------
module sa_rdata_channel #(
    parameter int MST_AMT          = 3,
    parameter int OUTSTANDING_AMT  = 8,
    parameter int MST_ID_W         = $clog2(MST_AMT),
    parameter int DATA_WIDTH       = 32,
    parameter int TRANS_MST_ID_W   = 5,
    parameter int TRANS_SLV_ID_W   = TRANS_MST_ID_W + $clog2(MST_AMT),
    parameter int TRANS_DATA_LEN_W = 3,
    parameter int TRANS_RESP_W     = 2
) (
    input  logic                        ACLK_i,
    input  logic                        ARESET_i,
    input  logic [TRANS_SLV_ID_W-1:0]   xADDR_AxID_i,
    input  logic [TRANS_DATA_LEN_W-1:0] xADDR_AxLEN_i,
    input  logic [MST_ID_W-1:0]         xADDR_mst_id_i,
    input  logic                        xADDR_crossing_flag_i,
    input  logic                        xADDR_fifo_order_wr_en_i,
    output logic                        xDATA_stall_o,
    input  logic [TRANS_SLV_ID_W-1:0]   s_RID_i,
    input  logic [DATA_WIDTH-1:0]       s_RDATA_i,
    input  logic [TRANS_RESP_W-1:0]     s_RRESP_i,
    input  logic                        s_RLAST_i,
    input  logic                        s_RVALID_i,
    output logic                        s_RREADY_o,
    output logic [TRANS_MST_ID_W-1:0]   dsp_RID_o,
    output logic [DATA_WIDTH-1:0]       dsp_RDATA_o,
    output logic [TRANS_RESP_W-1:0]     dsp_RRESP_o,
    output logic                        dsp_RLAST_o,
    output logic [MST_AMT-1:0]          dsp_RVALID_o,
    input  logic [MST_AMT-1:0]          dsp_RREADY_i,
    output logic                        prot_err_o
);

    localparam int PTR_W = $clog2(OUTSTANDING_AMT);
    localparam int CNT_W = PTR_W + 1;

    // Order FIFO storage (payload only, never reset)
    logic [TRANS_SLV_ID_W-1:0]   ord_id_q  [OUTSTANDING_AMT];
    logic [TRANS_DATA_LEN_W-1:0] ord_len_q [OUTSTANDING_AMT];
    logic [MST_ID_W-1:0]         ord_mst_q [OUTSTANDING_AMT];
    logic                        ord_cf_q  [OUTSTANDING_AMT];

    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [TRANS_DATA_LEN_W-1:0] beat_cnt_q, beat_cnt_d;
    logic                        prot_err_q, prot_err_d;

    logic                        fifo_empty, fifo_full;
    logic                        push_ok, pop, hs, last_beat, s_ready;
    logic [TRANS_SLV_ID_W-1:0]   head_id;
    logic [TRANS_DATA_LEN_W-1:0] head_len;
    logic [MST_ID_W-1:0]         head_mst;
    logic                        head_cf;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(OUTSTANDING_AMT));

    // First-word fall-through: the head record is read straight out of storage.
    assign head_id  = ord_id_q[rd_ptr_q];
    assign head_len = ord_len_q[rd_ptr_q];
    assign head_mst = ord_mst_q[rd_ptr_q];
    assign head_cf  = ord_cf_q[rd_ptr_q];

    assign hs        = s_RVALID_i & s_ready;
    assign last_beat = (beat_cnt_q == head_len);
    // A burst ends on its LEN count, independent of what the slave signals on RLAST.
    assign pop       = hs & last_beat;
    // When full, a push is still taken if the head leaves in the same cycle.
    assign push_ok   = xADDR_fifo_order_wr_en_i & (~fifo_full | pop);

    assign xDATA_stall_o = fifo_full;
    assign s_RREADY_o    = s_ready;
    assign prot_err_o    = prot_err_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        beat_cnt_d = beat_cnt_q;
        prot_err_d = prot_err_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (hs) begin
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
        end

        // Dropped push, wrong ID, or RLAST not lining up with the LEN count.
        if (xADDR_fifo_order_wr_en_i && !push_ok) begin
            prot_err_d = 1'b1;
        end
        if (hs && ((s_RID_i != head_id) || (s_RLAST_i != last_beat))) begin
            prot_err_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            beat_cnt_q <= '0;
            prot_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            beat_cnt_q <= beat_cnt_d;
            prot_err_q <= prot_err_d;
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (push_ok) begin
            ord_id_q[wr_ptr_q]  <= xADDR_AxID_i;
            ord_len_q[wr_ptr_q] <= xADDR_AxLEN_i;
            ord_mst_q[wr_ptr_q] <= xADDR_mst_id_i;
            ord_cf_q[wr_ptr_q]  <= xADDR_crossing_flag_i;
        end
    end

`ifdef SA_RDATA_OUT_REG_EN

    typedef struct packed {
        logic [MST_ID_W-1:0]       mst;
        logic [TRANS_MST_ID_W-1:0] id;
        logic [DATA_WIDTH-1:0]     data;
        logic [TRANS_RESP_W-1:0]   resp;
        logic                      last;
    } beat_t;

    beat_t       sk0_q, sk0_d, sk1_q, sk1_d, sk_in;
    logic [1:0]  sk_cnt_q, sk_cnt_d, sk_rem;
    logic        out_ready, out_pop;

    // Ready depends only on registered skid occupancy, so downstream ready
    // never reaches the slave combinationally.
    assign s_ready = ~fifo_empty & (sk_cnt_q != 2'd2);

    assign sk_in.mst  = head_mst;
    assign sk_in.id   = s_RID_i[TRANS_MST_ID_W-1:0];
    assign sk_in.data = s_RDATA_i;
    assign sk_in.resp = s_RRESP_i;
    assign sk_in.last = s_RLAST_i & ~head_cf;

    always_comb begin
        out_ready    = 1'b0;
        dsp_RVALID_o = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            if (sk0_q.mst == MST_ID_W'(i)) begin
                out_ready       = dsp_RREADY_i[i];
                dsp_RVALID_o[i] = (sk_cnt_q != 2'd0);
            end
        end
    end

    assign out_pop = (sk_cnt_q != 2'd0) & out_ready;

    // Entry 0 always drives the outputs; on a pop entry 1 shifts down and an
    // incoming beat lands in the first free slot.
    always_comb begin
        sk0_d  = sk0_q;
        sk1_d  = sk1_q;
        if (out_pop) begin
            sk0_d = sk1_q;
        end
        sk_rem = sk_cnt_q - {1'b0, out_pop};
        if (hs) begin
            if (sk_rem == 2'd0) begin
                sk0_d = sk_in;
            end else begin
                sk1_d = sk_in;
            end
        end
        sk_cnt_d = sk_rem + {1'b0, hs};
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            sk_cnt_q <= 2'd0;
        end else begin
            sk_cnt_q <= sk_cnt_d;
        end
    end

    always_ff @(posedge ACLK_i) begin
        sk0_q <= sk0_d;
        sk1_q <= sk1_d;
    end

    assign dsp_RID_o   = sk0_q.id;
    assign dsp_RDATA_o = sk0_q.data;
    assign dsp_RRESP_o = sk0_q.resp;
    assign dsp_RLAST_o = sk0_q.last;

`else

    logic sel_ready;

    always_comb begin
        sel_ready    = 1'b0;
        dsp_RVALID_o = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            if (head_mst == MST_ID_W'(i)) begin
                sel_ready       = dsp_RREADY_i[i];
                dsp_RVALID_o[i] = s_RVALID_i & ~fifo_empty;
            end
        end
    end

    assign s_ready     = ~fifo_empty & sel_ready;
    assign dsp_RID_o   = s_RID_i[TRANS_MST_ID_W-1:0];
    assign dsp_RDATA_o = s_RDATA_i;
    assign dsp_RRESP_o = s_RRESP_i;
    // First half of a 4KB split never shows RLAST to the master.
    assign dsp_RLAST_o = s_RLAST_i & ~head_cf;

`endif

endmodule
